// File: rtl/spi_rx_pkg.sv
// Shared types and elaboration-time helpers for the multi-lane SPI slave receiver.
package spi_rx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  function automatic bit lanes_ok(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

  function automatic bit word_ok(input int word_bits, input int lanes);
    return (lanes > 0) && (word_bits % lanes == 0) && (word_bits / lanes >= 2);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic int beat_cnt_w(input int word_bits, input int lanes);
    return $clog2(word_bits / lanes);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead word buffer for the SPI receiver. SPI_RX_FIFO_EN selects a DEPTH-entry
// FIFO; otherwise a single holding register. A push into a full buffer is dropped
// unless a pop is accepted in the same cycle.
module spi_rx_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read mux masks it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
`else
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign full     = full_q;
  assign empty    = !full_q;
  assign level    = LW'(full_q);
  assign pop_data = full_q ? hold_q : '0;

  always_comb begin
    do_pop  = pop && full_q;
    do_push = push && (!full_q || do_pop);
    hold_d  = do_push ? push_data : hold_q;
    full_d  = do_push ? 1'b1 : (do_pop ? 1'b0 : full_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

endmodule

// File: rtl/spi_slave_nlane_rx.sv
// Multi-lane SPI slave receiver: synchronizes pins, assembles little-endian words per
// chip-select frame and buffers them (SPI_RX_FIFO_EN: FIFO, else one holding register).
module spi_slave_nlane_rx
  import spi_rx_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int WORD_BITS   = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          spi_clk_in,
  input  logic                          spi_cs_n_in,
  input  logic [LANES-1:0]              spi_data_in,
  output logic [WORD_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_short,
  output logic                          err_overflow,
  input  logic                          err_clr,
  output logic                          irq_rx
);

  localparam int BEATS = WORD_BITS / LANES;
  localparam int BW    = beat_cnt_w(WORD_BITS, LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!lanes_ok(LANES) || !word_ok(WORD_BITS, LANES) || SYNC_STAGES < 2) begin : g_bad_param
    $error("spi_slave_nlane_rx: illegal LANES/WORD_BITS/SYNC_STAGES");
  end
`ifdef SPI_RX_FIFO_EN
  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("spi_slave_nlane_rx: FIFO_DEPTH must be a power of 2 >= 2");
  end
`endif

  logic [SYNC_STAGES-1:0]            clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]            cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]            vld_sync_q, vld_sync_d;
  logic [SYNC_STAGES-1:0][LANES-1:0] data_sync_q, data_sync_d;
  logic                              clk_d_q;

  logic                 clk_s, cs_s, cs_known, spi_edge;
  logic [LANES-1:0]     data_s;

  rx_state_e            state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic                 armed_q, armed_d;
  logic                 err_short_q, err_short_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 short_evt, ovf_evt, pop;
  logic                 fifo_full, fifo_empty;

  // vld_sync marks when the cs synchronizer holds a real pin sample rather than its
  // reset value, so a reset mid-frame cannot fake the "cs seen high" condition.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_in};
    vld_sync_d  = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], spi_data_in};
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign cs_known = vld_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign spi_edge = clk_s & ~clk_d_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    armed_d   = armed_q;
    short_evt = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (cs_known && cs_s) armed_d = 1'b1;
        if (armed_q && !cs_s) begin
          state_d = RECV;
          armed_d = 1'b0;
        end
      end
      RECV: begin
        // A beat coinciding with cs deassertion is dropped.
        if (cs_s) begin
          state_d   = IDLE;
          cnt_d     = '0;
          shift_d   = '0;
          short_evt = (cnt_q != '0);
        end else if (spi_edge) begin
          shift_d = {data_s, shift_q[WORD_BITS-1:LANES]};
          if (cnt_q == LAST_BEAT) begin
            cnt_d  = '0;
            push_d = 1'b1;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop     = rx_valid && rx_ready;
  assign ovf_evt = push_q && fifo_full && !pop;

  always_comb begin
    err_short_d = (err_short_q && !err_clr) || short_evt;
    err_ovf_d   = (err_ovf_q && !err_clr) || ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      vld_sync_q  <= '0;
      data_sync_q <= '0;
      clk_d_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      armed_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      cs_sync_q   <= cs_sync_d;
      vld_sync_q  <= vld_sync_d;
      data_sync_q <= data_sync_d;
      clk_d_q     <= clk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      armed_q     <= armed_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // shift_q holds the completed word for the cycle push_q is high.
  spi_rx_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rx_valid     = !fifo_empty;
  assign rx_busy      = (state_q == RECV);
  assign err_short    = err_short_q;
  assign err_overflow = err_ovf_q;
  assign irq_rx       = rx_valid | err_short_q | err_ovf_q;

endmodule

// File: tb/tb_spi_slave_nlane_rx.sv
// Directed bench for spi_slave_nlane_rx: an 8-lane/128-bit instance and a 2-lane/32-bit
// instance share the SPI pins; buffer capacity follows SPI_RX_FIFO_EN.
module tb_spi_slave_nlane_rx;

`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic         clk;
  logic         resetn;
  logic         spi_clk;
  logic         spi_cs_n;
  logic [7:0]   spi_data;
  logic         err_clr;

  logic [127:0] rx_data8;
  logic         rx_valid8, rx_ready8, rx_busy8, err_short8, err_ovf8, irq8;
  logic [2:0]   level8;

  logic [31:0]  rx_data2;
  logic         rx_valid2, rx_ready2, rx_busy2, err_short2, err_ovf2, irq2;
  logic [2:0]   level2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [31:0]  exp2_q[$];
  logic [127:0] word_buf[8];
  logic         mon2_en = 1'b0;
  int           max_level2 = 0;

  spi_slave_nlane_rx #(.LANES(8), .WORD_BITS(128), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .resetn(resetn), .spi_clk_in(spi_clk), .spi_cs_n_in(spi_cs_n),
    .spi_data_in(spi_data), .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
    .rx_busy(rx_busy8), .fifo_level(level8), .err_short(err_short8),
    .err_overflow(err_ovf8), .err_clr(err_clr), .irq_rx(irq8)
  );

  spi_slave_nlane_rx #(.LANES(2), .WORD_BITS(32), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .resetn(resetn), .spi_clk_in(spi_clk), .spi_cs_n_in(spi_cs_n),
    .spi_data_in(spi_data[1:0]), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .rx_busy(rx_busy2), .fifo_level(level2), .err_short(err_short2),
    .err_overflow(err_ovf2), .err_clr(err_clr), .irq_rx(irq2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for the 2-lane instance, which always has rx_ready high.
  always @(negedge clk) begin
    if (mon2_en) begin
      if (int'(level2) > max_level2) max_level2 = int'(level2);
      if (rx_valid2) begin
        if (exp2_q.size() == 0) check("l2_unexpected_word", 128'(rx_data2), 128'h0);
        else check("l2_word", 128'(rx_data2), 128'(exp2_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  // mode 1: check push latency; mode 2: accept a pop in the push cycle of a full buffer
  task automatic beat(input logic [7:0] d, input int mode);
    spi_data = d;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      check("latency_not_early", 128'(rx_valid8), 128'h0);
      @(negedge clk);
      check("latency_valid", 128'(rx_valid8), 128'h1);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      check("full_before_pop", 128'(level8), 128'(CAP));
      check("full_pop_head", rx_data8, exp_q.pop_front());
      rx_ready8 = 1'b1;
      @(negedge clk);
      rx_ready8 = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
    end
    spi_clk = 1'b0;
  endtask

  task automatic send_stream(input int nbeats, input int mode_beat, input int mode);
    logic [127:0] w;
    for (int i = 0; i < nbeats; i++) begin
      w = word_buf[(i / 16) % 8];
      beat(w[8*(i%16) +: 8], (i == mode_beat) ? mode : 0);
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input int n);
    rx_ready8 = 1'b1;
    for (int k = 0; k < n; k++) begin
      check("drain_valid", 128'(rx_valid8), 128'h1);
      check("drain_word", rx_data8, exp_q.pop_front());
      @(negedge clk);
    end
    rx_ready8 = 1'b0;
    check("drain_empty", 128'(rx_valid8), 128'h0);
    check("drain_level", 128'(level8), 128'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(rx_valid8), 128'h0);
    check({tag, "_data"}, rx_data8, 128'h0);
    check({tag, "_busy"}, 128'(rx_busy8), 128'h0);
    check({tag, "_level"}, 128'(level8), 128'h0);
    check({tag, "_flags"}, 128'({err_short8, err_ovf8, irq8}), 128'h0);
  endtask

  typedef struct {
    int           beats;
    logic [127:0] word;
    int           mode;
    logic         exp_valid;
    logic         exp_short;
  } vec_t;

  vec_t vecs[6];

  initial begin
    resetn = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_data = '0;
    err_clr = 1'b0; rx_ready8 = 1'b0; rx_ready2 = 1'b1;

    vecs[0] = '{16, 128'h0F0E0D0C0B0A09080706050403020100, 1, 1'b1, 1'b0};
    vecs[1] = '{16, 128'h0123456789ABCDEFFEDCBA9876543210, 0, 1'b1, 1'b0};
    vecs[2] = '{5,  128'h55AA55AA55AA55AA55AA55AA55AA55AA, 0, 1'b0, 1'b1};
    vecs[3] = '{16, {128{1'b1}},                           0, 1'b1, 1'b0};
    vecs[4] = '{0,  128'h0,                                0, 1'b0, 1'b0};
    vecs[5] = '{17, 128'hA5A5A5A5C3C3C3C30F0F0F0F00000001, 0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 6; i++) begin
      pulse_clr();
      word_buf[0] = vecs[i].word;
      word_buf[1] = vecs[i].word;
      cs_begin();
      check($sformatf("v%0d_busy", i), 128'(rx_busy8), 128'h1);
      send_stream(vecs[i].beats, 15, vecs[i].mode);
      cs_end();
      check($sformatf("v%0d_busy_end", i), 128'(rx_busy8), 128'h0);
      check($sformatf("v%0d_valid", i), 128'(rx_valid8), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("v%0d_data", i), rx_data8, vecs[i].word);
      check($sformatf("v%0d_short", i), 128'(err_short8), 128'(vecs[i].exp_short));
      check($sformatf("v%0d_irq", i), 128'(irq8), 128'(vecs[i].exp_valid | vecs[i].exp_short));
      check($sformatf("v%0d_ovf", i), 128'(err_ovf8), 128'h0);
      rx_ready8 = 1'b1;
      @(negedge clk);
      rx_ready8 = 1'b0;
      check($sformatf("v%0d_popped", i), 128'(rx_valid8), 128'h0);
    end

    // Short flag left set by the last vector; clear it.
    pulse_clr();
    check("clr_short", 128'(err_short8), 128'h0);
    check("clr_irq", 128'(irq8), 128'h0);

    // Overflow: five words, nothing consumed.
    for (int k = 0; k < 5; k++) word_buf[k] = {4{32'h1000_0001 * 32'(k + 1)}};
    cs_begin();
    send_stream(80, -1, 0);
    cs_end();
    check("ovf_level", 128'(level8), 128'(CAP));
    check("ovf_flag", 128'(err_ovf8), 128'h1);
    check("ovf_irq", 128'(irq8), 128'h1);
    check("ovf_short", 128'(err_short8), 128'h0);
    for (int k = 0; k < CAP; k++) exp_q.push_back(word_buf[k]);
    drain(CAP);
    pulse_clr();
    check("ovf_clr", 128'(err_ovf8), 128'h0);

    // Full buffer, pop accepted in the same cycle as the next push.
    for (int k = 0; k <= CAP; k++) begin
      word_buf[k] = {4{32'hBEEF_0000 + 32'(k * 7 + 3)}};
      exp_q.push_back(word_buf[k]);
    end
    cs_begin();
    send_stream(16 * (CAP + 1), 16 * CAP + 15, 2);
    cs_end();
    check("full_pop_ovf", 128'(err_ovf8), 128'h0);
    check("full_pop_level", 128'(level8), 128'(CAP));
    drain(CAP);

    // Reset mid-frame with a buffered word and a partial word.
    word_buf[0] = 128'hFACE_0001_FACE_0002_FACE_0003_FACE_0004;
    word_buf[1] = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    cs_begin();
    send_stream(23, -1, 0);
    check("pre_reset_level", 128'(level8), 128'h1);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midframe_reset");
    resetn = 1'b1;
    word_buf[0] = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    send_stream(16, -1, 0);
    check("no_rx_after_reset_valid", 128'(rx_valid8), 128'h0);
    check("no_rx_after_reset_busy", 128'(rx_busy8), 128'h0);
    cs_end();
    check("no_rx_after_reset_short", 128'(err_short8), 128'h0);
    word_buf[0] = 128'h3141_5926_5358_9793_2384_6264_3383_2795;
    cs_begin();
    send_stream(16, -1, 0);
    cs_end();
    check("resume_valid", 128'(rx_valid8), 128'h1);
    check("resume_data", rx_data8, word_buf[0]);
    rx_ready8 = 1'b1;
    @(negedge clk);

    // 2-lane instance: three 32-bit words in one frame, consumer always ready.
    pulse_clr();
    word_buf[0] = {96'h0, 32'hDEADBEEF};
    word_buf[1] = {96'h0, 32'h12345678};
    word_buf[2] = {96'h0, 32'hA5C30F96};
    for (int k = 0; k < 3; k++) exp2_q.push_back(word_buf[k][31:0]);
    mon2_en = 1'b1;
    cs_begin();
    for (int i = 0; i < 48; i++) begin
      logic [127:0] w;
      w = word_buf[i / 16];
      beat({6'b0, w[2*(i%16) +: 2]}, 0);
    end
    cs_end();
    mon2_en = 1'b0;
    check("l2_all_popped", 128'(exp2_q.size()), 128'h0);
    check("l2_level_max", 128'(max_level2 <= 1), 128'h1);
    check("l2_flags", 128'({err_short2, err_ovf2}), 128'h0);
    check("l2_busy_end", 128'(rx_busy2), 128'h0);
    rx_ready8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
